// File: rtl/lock_pkg.sv
// lock_pkg: shared types and constants for the lock sequencer.
//   lock_state_t   - FSM state enum (CHECKING is internal, reported as editing)
//   SO_*           - 2-bit state_out encodings
//   LED_*          - LED patterns per state
//   DEF_*          - default timing / policy constants
//   so_code/led_code - map an FSM state to its externally visible encodings
package lock_pkg;

  typedef enum logic [2:0] {
    ST_WAITING  = 3'd0,
    ST_EDITING  = 3'd1,
    ST_CHECKING = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_ALARMING = 3'd4
  } lock_state_t;

  localparam logic [1:0] SO_WAITING  = 2'b00;
  localparam logic [1:0] SO_EDITING  = 2'b01;
  localparam logic [1:0] SO_UNLOCKED = 2'b10;
  localparam logic [1:0] SO_ALARMING = 2'b11;

  localparam logic [3:0] LED_WAITING = 4'b0001;
  localparam logic [3:0] LED_EDITING = 4'b0011;
  localparam logic [3:0] LED_ON      = 4'b1111;
  localparam logic [3:0] LED_OFF     = 4'b0000;

  localparam int DEF_TICKS_PER_SEC    = 50_000_000;
  localparam int DEF_EDIT_TIMEOUT_S   = 10;
  localparam int DEF_UNLOCK_TIMEOUT_S = 20;
  localparam int DEF_MAX_ERRORS       = 3;

  function automatic logic [1:0] so_code(input lock_state_t s);
    case (s)
      ST_WAITING:               so_code = SO_WAITING;
      ST_EDITING, ST_CHECKING:  so_code = SO_EDITING;
      ST_UNLOCKED:              so_code = SO_UNLOCKED;
      default:                  so_code = SO_ALARMING;
    endcase
  endfunction

  // Alarm blinking is handled by the caller; this gives the steady pattern.
  function automatic logic [3:0] led_code(input lock_state_t s);
    case (s)
      ST_WAITING:               led_code = LED_WAITING;
      ST_EDITING, ST_CHECKING:  led_code = LED_EDITING;
      default:                  led_code = LED_ON;
    endcase
  endfunction

endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that flags expiry exactly N cycles after
// a load of N.
//   clk, reset_n - clock, asynchronous active-low reset (counter idle)
//   load         - load load_value this cycle (overrides everything)
//   load_value   - cycle count until expiry
//   freeze       - hold the count and suppress expiry
//   expire       - one-cycle pulse in the final cycle of the countdown
module lock_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             freeze,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Zero means idle, so a count of 1 is the last cycle before the N-th edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (!freeze && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = (cnt == CNT_W'(1)) && !freeze;

endmodule

// File: rtl/lock_sequencer.sv
// lock_sequencer: control FSM for a code lock.
//   clk, reset_n           - clock, asynchronous active-low reset
//   edit_sw                - level switch, rising edge starts code entry
//   activity               - pulse on digit load/delete (restarts edit timeout)
//   ok_btn                 - confirm pulse
//   admin_clr              - administrator clear pulse
//   check_ack, check_match - comparator handshake (match valid with ack)
//   check_req              - compare request, held until acknowledged
//   entry_en               - digit entry permitted
//   entry_clr              - one-cycle clear of the digit register
//   state_out              - 00 waiting, 01 editing, 10 unlocked, 11 alarming
//   err_count              - wrong-attempt count, saturating
//   leds                   - state indication, blinking while alarming
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int TICKS_PER_SEC    = DEF_TICKS_PER_SEC,
  parameter int EDIT_TIMEOUT_S   = DEF_EDIT_TIMEOUT_S,
  parameter int UNLOCK_TIMEOUT_S = DEF_UNLOCK_TIMEOUT_S,
  parameter int MAX_ERRORS       = DEF_MAX_ERRORS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       edit_sw,
  input  logic       activity,
  input  logic       ok_btn,
  input  logic       admin_clr,
  input  logic       check_ack,
  input  logic       check_match,
  output logic       check_req,
  output logic       entry_en,
  output logic       entry_clr,
  output logic [1:0] state_out,
  output logic [1:0] err_count,
  output logic [3:0] leds
);

  localparam longint EDIT_N   = longint'(EDIT_TIMEOUT_S) * longint'(TICKS_PER_SEC);
  localparam longint UNLOCK_N = longint'(UNLOCK_TIMEOUT_S) * longint'(TICKS_PER_SEC);
  localparam longint MAX_N    = (EDIT_N > UNLOCK_N) ? EDIT_N : UNLOCK_N;
  localparam int     TMR_W    = (MAX_N > 1) ? $clog2(MAX_N + 1) : 1;

  localparam logic [TMR_W-1:0] EDIT_LD   = TMR_W'(EDIT_N);
  localparam logic [TMR_W-1:0] UNLOCK_LD = TMR_W'(UNLOCK_N);

  // err_count is 2 bits wide, so the alarm threshold is clamped to 1..3.
  localparam int         MAX_C = (MAX_ERRORS > 3) ? 3 : ((MAX_ERRORS < 1) ? 1 : MAX_ERRORS);
  localparam logic [1:0] MAX_E = 2'(MAX_C);

  localparam int HALF  = (TICKS_PER_SEC / 2 < 1) ? 1 : TICKS_PER_SEC / 2;
  localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

  lock_state_t      state;
  lock_state_t      nxt_state;
  logic [1:0]       nxt_err;
  logic [1:0]       err_inc;
  logic             clr_nxt;
  logic             edit_q;
  logic             edit_rise;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expire;
  logic [BLK_W-1:0] blink_cnt;

  // edit_q resets to 0, so a switch held high through reset counts as a rise.
  assign edit_rise = edit_sw & ~edit_q;

  lock_timer #(
    .CNT_W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_val),
    .freeze     (state == ST_CHECKING),
    .expire     (tmr_expire)
  );

  assign err_inc = (err_count >= MAX_E) ? MAX_E : err_count + 2'd1;

  always_comb begin
    nxt_state = state;
    nxt_err   = err_count;
    clr_nxt   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = EDIT_LD;
    case (state)
      ST_WAITING: begin
        if (edit_rise) begin
          nxt_state = ST_EDITING;
          clr_nxt   = 1'b1;
          tmr_load  = 1'b1;
        end
      end
      ST_EDITING: begin
        // ok_btn takes priority over both expiry and activity.
        if (ok_btn) begin
          nxt_state = ST_CHECKING;
        end else if (tmr_expire) begin
          nxt_state = ST_WAITING;
          clr_nxt   = 1'b1;
        end else if (activity) begin
          tmr_load = 1'b1;
        end
      end
      ST_CHECKING: begin
        if (check_ack) begin
          if (check_match) begin
            nxt_state = ST_UNLOCKED;
            nxt_err   = 2'd0;
            clr_nxt   = 1'b1;
            tmr_load  = 1'b1;
            tmr_val   = UNLOCK_LD;
          end else begin
            nxt_err = err_inc;
            if (err_inc == MAX_E) begin
              nxt_state = ST_ALARMING;
            end else begin
              nxt_state = ST_EDITING;
              clr_nxt   = 1'b1;
              tmr_load  = 1'b1;
            end
          end
        end
      end
      ST_UNLOCKED: begin
        if (ok_btn || tmr_expire) begin
          nxt_state = ST_WAITING;
        end
      end
      ST_ALARMING: begin
        if (admin_clr) begin
          nxt_state = ST_WAITING;
        end
      end
      default: begin
        nxt_state = ST_WAITING;
      end
    endcase
    if (admin_clr) begin
      nxt_err = 2'd0;
    end
  end

  // All outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_WAITING;
      edit_q    <= 1'b0;
      err_count <= 2'd0;
      entry_clr <= 1'b0;
      entry_en  <= 1'b0;
      check_req <= 1'b0;
      state_out <= SO_WAITING;
      leds      <= LED_WAITING;
      blink_cnt <= '0;
    end else begin
      state     <= nxt_state;
      edit_q    <= edit_sw;
      err_count <= nxt_err;
      entry_clr <= clr_nxt;
      entry_en  <= (nxt_state == ST_EDITING);
      check_req <= (nxt_state == ST_CHECKING);
      state_out <= so_code(nxt_state);
      if (nxt_state == ST_ALARMING) begin
        if (state != ST_ALARMING) begin
          leds      <= LED_ON;
          blink_cnt <= '0;
        end else if (blink_cnt == BLK_W'(HALF - 1)) begin
          leds      <= ~leds;
          blink_cnt <= '0;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end else begin
        leds      <= led_code(nxt_state);
        blink_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
`timescale 1ns/1ps
module tb_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       edit_sw = 1'b0;
  logic       activity = 1'b0;
  logic       ok_btn = 1'b0;
  logic       admin_clr = 1'b0;
  logic       check_ack = 1'b0;
  logic       check_match = 1'b0;
  logic       check_req;
  logic       entry_en;
  logic       entry_clr;
  logic [1:0] state_out;
  logic [1:0] err_count;
  logic [3:0] leds;

  int n_tests = 0;
  int n_fail  = 0;

  lock_sequencer #(
    .TICKS_PER_SEC    (4),
    .EDIT_TIMEOUT_S   (10),
    .UNLOCK_TIMEOUT_S (20),
    .MAX_ERRORS       (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .edit_sw     (edit_sw),
    .activity    (activity),
    .ok_btn      (ok_btn),
    .admin_clr   (admin_clr),
    .check_ack   (check_ack),
    .check_match (check_match),
    .check_req   (check_req),
    .entry_en    (entry_en),
    .entry_clr   (entry_clr),
    .state_out   (state_out),
    .err_count   (err_count),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({state_out, err_count, leds} !== {2'b00, 2'b00, 4'b0001}) begin
      $display("FAIL reset_state: state/err/leds got %b/%b/%b want 00/00/0001", state_out, err_count, leds);
      n_fail++;
    end
    n_tests++;
    if ({check_req, entry_en, entry_clr} !== 3'b000) begin
      $display("FAIL reset_ctrl: req/en/clr got %b want 000", {check_req, entry_en, entry_clr});
      n_fail++;
    end
    @(negedge clk) reset_n = 1'b1;
    step();
    n_tests++;
    if (state_out !== 2'b00) begin
      $display("FAIL reset_idle: state_out got %b want 00", state_out);
      n_fail++;
    end
  endtask

  task automatic test_unlock();
    edit_sw = 1'b1;
    step();
    n_tests++;
    if ({state_out, entry_clr, entry_en, leds} !== {2'b01, 1'b1, 1'b1, 4'b0011}) begin
      $display("FAIL unlock_enter_edit: state/clr/en/leds got %b/%b/%b/%b want 01/1/1/0011",
               state_out, entry_clr, entry_en, leds);
      n_fail++;
    end
    step();
    n_tests++;
    if (entry_clr !== 1'b0) begin
      $display("FAIL unlock_clr_pulse: entry_clr got %b want 0", entry_clr);
      n_fail++;
    end
    ok_btn = 1'b1;
    step();
    ok_btn = 1'b0;
    n_tests++;
    if ({state_out, check_req, entry_en} !== {2'b01, 1'b1, 1'b0}) begin
      $display("FAIL unlock_checking: state/req/en got %b/%b/%b want 01/1/0", state_out, check_req, entry_en);
      n_fail++;
    end
    step();
    step();
    check_ack = 1'b1;
    check_match = 1'b1;
    step();
    check_ack = 1'b0;
    check_match = 1'b0;
    n_tests++;
    if ({state_out, err_count, leds, check_req, entry_clr} !== {2'b10, 2'b00, 4'b1111, 1'b0, 1'b1}) begin
      $display("FAIL unlock_open: state/err/leds/req/clr got %b/%b/%b/%b/%b want 10/00/1111/0/1",
               state_out, err_count, leds, check_req, entry_clr);
      n_fail++;
    end
    // Switch re-toggle and activity must be ignored while unlocked.
    for (int i = 1; i < 80; i++) begin
      if (i == 10) edit_sw = 1'b0;
      if (i == 11) edit_sw = 1'b1;
      activity = (i == 20);
      step();
    end
    activity = 1'b0;
    n_tests++;
    if (state_out !== 2'b10) begin
      $display("FAIL unlock_hold79: state_out got %b want 10", state_out);
      n_fail++;
    end
    step();
    n_tests++;
    if ({state_out, leds} !== {2'b00, 4'b0001}) begin
      $display("FAIL unlock_expire80: state/leds got %b/%b want 00/0001", state_out, leds);
      n_fail++;
    end
    edit_sw = 1'b0;
    step();
  endtask

  task automatic test_errors();
    edit_sw = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      ok_btn = 1'b1;
      step();
      ok_btn = 1'b0;
      check_ack = 1'b1;
      check_match = 1'b0;
      step();
      check_ack = 1'b0;
      n_tests++;
      if (err_count !== 2'(k)) begin
        $display("FAIL err_count_%0d: err_count got %0d want %0d", k, err_count, k);
        n_fail++;
      end
      if (k < 3) begin
        n_tests++;
        if ({state_out, entry_clr, entry_en} !== {2'b01, 1'b1, 1'b1}) begin
          $display("FAIL err_retry_%0d: state/clr/en got %b/%b/%b want 01/1/1", k, state_out, entry_clr, entry_en);
          n_fail++;
        end
      end
    end
    n_tests++;
    if ({state_out, leds} !== {2'b11, 4'b1111}) begin
      $display("FAIL alarm_enter: state/leds got %b/%b want 11/1111", state_out, leds);
      n_fail++;
    end
    step();
    n_tests++;
    if (leds !== 4'b1111) begin
      $display("FAIL alarm_blink1: leds got %b want 1111", leds);
      n_fail++;
    end
    step();
    n_tests++;
    if (leds !== 4'b0000) begin
      $display("FAIL alarm_blink2: leds got %b want 0000", leds);
      n_fail++;
    end
    step();
    n_tests++;
    if (leds !== 4'b0000) begin
      $display("FAIL alarm_blink3: leds got %b want 0000", leds);
      n_fail++;
    end
    step();
    n_tests++;
    if (leds !== 4'b1111) begin
      $display("FAIL alarm_blink4: leds got %b want 1111", leds);
      n_fail++;
    end
    ok_btn = 1'b1;
    step();
    ok_btn = 1'b0;
    edit_sw = 1'b0;
    step();
    edit_sw = 1'b1;
    step();
    n_tests++;
    if ({state_out, err_count} !== {2'b11, 2'b11}) begin
      $display("FAIL alarm_ignore: state/err got %b/%b want 11/11", state_out, err_count);
      n_fail++;
    end
    admin_clr = 1'b1;
    step();
    admin_clr = 1'b0;
    n_tests++;
    if ({state_out, err_count, leds} !== {2'b00, 2'b00, 4'b0001}) begin
      $display("FAIL alarm_admin_clr: state/err/leds got %b/%b/%b want 00/00/0001", state_out, err_count, leds);
      n_fail++;
    end
    edit_sw = 1'b0;
    step();
  endtask

  task automatic test_edit_timeout();
    int clr_pulses;
    edit_sw = 1'b1;
    step();
    clr_pulses = 0;
    for (int i = 1; i < 40; i++) begin
      step();
      if (entry_clr === 1'b1) clr_pulses++;
    end
    n_tests++;
    if (state_out !== 2'b01) begin
      $display("FAIL timeout_hold39: state_out got %b want 01", state_out);
      n_fail++;
    end
    step();
    if (entry_clr === 1'b1) clr_pulses++;
    n_tests++;
    if ({state_out, clr_pulses} !== {2'b00, 32'd1}) begin
      $display("FAIL timeout_40: state_out got %b clr_pulses %0d want 00 and 1", state_out, clr_pulses);
      n_fail++;
    end
    edit_sw = 1'b0;
    step();
    edit_sw = 1'b1;
    step();
    for (int i = 1; i < 70; i++) begin
      activity = (i == 30);
      step();
    end
    activity = 1'b0;
    n_tests++;
    if (state_out !== 2'b01) begin
      $display("FAIL timeout_reload_hold69: state_out got %b want 01", state_out);
      n_fail++;
    end
    step();
    n_tests++;
    if (state_out !== 2'b00) begin
      $display("FAIL timeout_reload_70: state_out got %b want 00", state_out);
      n_fail++;
    end
    edit_sw = 1'b0;
    step();
  endtask

  task automatic test_err_persist();
    edit_sw = 1'b1;
    step();
    ok_btn = 1'b1;
    step();
    ok_btn = 1'b0;
    check_ack = 1'b1;
    check_match = 1'b0;
    step();
    check_ack = 1'b0;
    for (int i = 1; i < 40; i++) step();
    n_tests++;
    if (state_out !== 2'b01) begin
      $display("FAIL persist_hold39: state_out got %b want 01", state_out);
      n_fail++;
    end
    step();
    n_tests++;
    if ({state_out, err_count} !== {2'b00, 2'b01}) begin
      $display("FAIL persist_timeout: state/err got %b/%b want 00/01", state_out, err_count);
      n_fail++;
    end
    admin_clr = 1'b1;
    step();
    admin_clr = 1'b0;
    n_tests++;
    if ({state_out, err_count} !== {2'b00, 2'b00}) begin
      $display("FAIL persist_admin_clr: state/err got %b/%b want 00/00", state_out, err_count);
      n_fail++;
    end
    edit_sw = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic req_held;
    edit_sw = 1'b1;
    step();
    for (int i = 1; i < 40; i++) step();
    // Expiry, activity and ok_btn all land on the same edge; ok_btn wins.
    ok_btn = 1'b1;
    activity = 1'b1;
    step();
    ok_btn = 1'b0;
    activity = 1'b0;
    n_tests++;
    if ({state_out, check_req, entry_en, entry_clr} !== {2'b01, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL b2b_checking: state/req/en/clr got %b/%b/%b/%b want 01/1/0/0",
               state_out, check_req, entry_en, entry_clr);
      n_fail++;
    end
    req_held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (check_req !== 1'b1 || state_out !== 2'b01) req_held = 1'b0;
    end
    n_tests++;
    if (req_held !== 1'b1) begin
      $display("FAIL b2b_req_held: check_req/state_out got %b/%b want held 1/01", check_req, state_out);
      n_fail++;
    end
    check_ack = 1'b1;
    check_match = 1'b0;
    step();
    check_ack = 1'b0;
    n_tests++;
    if ({state_out, check_req, entry_en, err_count} !== {2'b01, 1'b0, 1'b1, 2'b01}) begin
      $display("FAIL b2b_ack: state/req/en/err got %b/%b/%b/%b want 01/0/1/01",
               state_out, check_req, entry_en, err_count);
      n_fail++;
    end
    check_ack = 1'b1;
    check_match = 1'b1;
    step();
    check_ack = 1'b0;
    check_match = 1'b0;
    n_tests++;
    if (state_out !== 2'b01) begin
      $display("FAIL b2b_stray_ack: state_out got %b want 01", state_out);
      n_fail++;
    end
    admin_clr = 1'b1;
    step();
    admin_clr = 1'b0;
    n_tests++;
    if ({state_out, err_count} !== {2'b01, 2'b00}) begin
      $display("FAIL b2b_admin_edit: state/err got %b/%b want 01/00", state_out, err_count);
      n_fail++;
    end
    for (int i = 3; i < 40; i++) step();
    n_tests++;
    if (state_out !== 2'b01) begin
      $display("FAIL b2b_hold39: state_out got %b want 01", state_out);
      n_fail++;
    end
    step();
    n_tests++;
    if (state_out !== 2'b00) begin
      $display("FAIL b2b_timeout40: state_out got %b want 00", state_out);
      n_fail++;
    end
    edit_sw = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_check();
    edit_sw = 1'b1;
    step();
    ok_btn = 1'b1;
    step();
    ok_btn = 1'b0;
    check_ack = 1'b1;
    check_match = 1'b0;
    step();
    check_ack = 1'b0;
    ok_btn = 1'b1;
    step();
    ok_btn = 1'b0;
    n_tests++;
    if ({check_req, err_count} !== {1'b1, 2'b01}) begin
      $display("FAIL rstchk_pre: req/err got %b/%b want 1/01", check_req, err_count);
      n_fail++;
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if ({state_out, err_count, leds, check_req, entry_en, entry_clr} !==
        {2'b00, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL rstchk_async: state/err/leds/req/en/clr got %b/%b/%b/%b/%b/%b want 00/00/0001/0/0/0",
               state_out, err_count, leds, check_req, entry_en, entry_clr);
      n_fail++;
    end
    edit_sw = 1'b0;
    step();
    @(negedge clk) reset_n = 1'b1;
    check_ack = 1'b1;
    check_match = 1'b1;
    step();
    check_ack = 1'b0;
    check_match = 1'b0;
    step();
    n_tests++;
    if ({state_out, check_req, err_count} !== {2'b00, 1'b0, 2'b00}) begin
      $display("FAIL rstchk_late_ack: state/req/err got %b/%b/%b want 00/0/00", state_out, check_req, err_count);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_errors();
    test_edit_timeout();
    test_err_persist();
    test_back_to_back();
    test_reset_mid_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 Parameters SHALL be: TICKS_PER_SEC default 50_000_000, clk cycles per second; EDIT_TIMEOUT_S default 10, editing idle limit; UNLOCK_TIMEOUT_S default 20, unlocked limit; MAX_ERRORS default 3, wrong attempts before alarm.
REQ-002 Ports SHALL be, in order: clk in 1, single clock, all logic on its rising edge; reset_n in 1, asynchronous active-low reset.
REQ-003 edit_sw in 1: level switch; only its rising edge is acted on, detected in clk domain.
REQ-004 activity in 1: single-cycle pulse on any digit load or delete.
REQ-005 ok_btn in 1: single-cycle confirm pulse.
REQ-006 admin_clr in 1: single-cycle administrator clear pulse.
REQ-007 check_ack in 1 and check_match in 1: comparator handshake; check_match is valid only while check_ack=1.
REQ-008 check_req out 1: password compare request.
REQ-009 entry_en out 1: digit entry permitted.
REQ-010 entry_clr out 1: single-cycle pulse that clears the digit register.
REQ-011 state_out out 2: 00 waiting, 01 editing, 10 unlocked, 11 alarming.
REQ-012 err_count out 2: wrong-attempt count.
REQ-013 leds out 4: state indication.

Function
REQ-014 The FSM SHALL have states WAITING, EDITING, CHECKING, UNLOCKED and ALARMING; CHECKING SHALL report state_out=01.
REQ-015 WAITING: an edit_sw rising edge SHALL move to EDITING, pulse entry_clr in that cycle, and load the timer with EDIT_TIMEOUT_S*TICKS_PER_SEC.
REQ-016 EDITING: entry_en=1; each activity pulse SHALL reload the edit timeout.
REQ-017 EDITING: ok_btn SHALL move to CHECKING.
REQ-018 EDITING: timer expiry SHALL move to WAITING and pulse entry_clr.
REQ-019 EDITING: when ok_btn coincides with activity or expiry, ok_btn SHALL win.
REQ-020 CHECKING: check_req SHALL be held at 1 until the cycle check_ack=1, deasserting the next cycle; entry_en=0; the timer is frozen.
REQ-021 Ack with match=1 SHALL move to UNLOCKED, clear err_count, pulse entry_clr, and load UNLOCK_TIMEOUT_S*TICKS_PER_SEC.
REQ-022 Ack with match=0 SHALL increment err_count. If the new value equals MAX_ERRORS, go to ALARMING. Otherwise return to EDITING, pulse entry_clr and reload the edit timeout.
REQ-023 UNLOCKED: ok_btn or timer expiry SHALL move to WAITING; activity is ignored.
REQ-024 ALARMING: only admin_clr SHALL exit, to WAITING, clearing err_count; ok_btn and edit_sw are ignored.
REQ-025 admin_clr in any other state SHALL clear err_count only; no state change.
REQ-026 err_count SHALL persist across an edit timeout, saturate at MAX_ERRORS, and never wrap.
REQ-027 edit_sw edges outside WAITING and check_ack outside CHECKING SHALL be ignored.
REQ-028 Timer expiry SHALL occur exactly N cycles after load, where N = seconds*TICKS_PER_SEC; expiry is a one-cycle internal pulse.
REQ-029 leds SHALL be: WAITING 0001; EDITING/CHECKING 0011; UNLOCKED 1111.
REQ-030 In ALARMING, leds SHALL toggle between 1111 and 0000 every TICKS_PER_SEC/2 cycles, starting at 1111 on entry.
REQ-031 All outputs SHALL be registered; state_out SHALL change one cycle after the triggering input.

Reset
REQ-032 reset_n low SHALL asynchronously force: WAITING, state_out=00, err_count=0, leds=0001, check_req=0, entry_en=0, entry_clr=0, timer idle, edge detector primed with edit_sw treated as 0.
REQ-033 Reset asserted mid-CHECKING SHALL abandon the handshake; a late check_ack after release SHALL be ignored.

Structure
REQ-034 Package lock_pkg SHALL hold the state enum, the 2-bit state_out encodings and the default timing constants.
REQ-035 The countdown SHALL be a sub-module lock_timer with load, load_value, freeze and expire ports; its width is sized for the larger timeout.

Verification (TICKS_PER_SEC=4, EDIT_TIMEOUT_S=10, UNLOCK_TIMEOUT_S=20, MAX_ERRORS=3)
REQ-036 edit_sw rise, ok_btn, ack with match=1 -> state_out 01 -> 10, err_count=0, leds=1111; no ok_btn -> 00 exactly 80 cycles after entering UNLOCKED.
REQ-037 Three ok_btn + ack with match=0 sequences -> err_count 1, 2, 3; state_out=11 after the third; leds toggle every 2 cycles; admin_clr -> 00, err_count=0.
REQ-038 Enter EDITING with no activity -> state_out=00 exactly 40 cycles later with one entry_clr pulse; activity at cycle 30 -> expiry moves to cycle 70.
REQ-039 ok_btn and activity in the same cycle -> CHECKING entered, check_req held until ack, timer frozen during a 5-cycle ack delay.
REQ-040 reset_n pulled low while check_req=1 -> immediate WAITING with all outputs at reset values; a subsequent check_ack has no effect.
